dpi_stream_sequencer: RTL and testbench
=======================================

// Module: dpi_stream_sequencer
// PURPOSE
//  Front end that drives the per-regex stream-state wrappers. Takes framed packet bytes plus a flow key,
//  maps the key to a 6-bit stream id through a 64-entry associative flow table, and issues the protocol
//  to all matchers: load_state / new_stream_id, then char bytes with char_vld, then an eop pulse.
//  Also supplies each matcher's per-stream enable bit from a config-written mask table.
// PARAMETERS
//  NUM_REGEX  16  number of matcher wrappers; width of enable vector / mask entries
//  KEY_W      16  flow key width
//  STREAM_W    6  stream id width; table depth NUM_STREAMS = 2**STREAM_W
// PORTS
//  clk           in   1          clock
//  rst_n         in   1          reset, asynchronous, active-low
//  pkt_data      in   8          packet byte
//  pkt_vld       in   1          byte valid
//  pkt_sop       in   1          first byte of packet
//  pkt_eop       in   1          last byte of packet
//  pkt_key       in   KEY_W      flow key, valid with pkt_sop
//  pkt_rdy       out  1          byte accepted when pkt_vld & pkt_rdy
//  char_in       out  8          byte to matchers
//  char_in_vld   out  1          char_in valid
//  eop           out  1          end-of-packet pulse, one cycle
//  load_state    out  1          one-cycle pulse: matchers restore/reset state
//  stream_id     out  STREAM_W   stream id, held from load_state through eop
//  new_stream_id out  1          with load_state: key was a table miss
//  enable        out  NUM_REGEX  per-matcher enable, held from load_state through eop
//  cfg_we        in   1          write mask table entry
//  cfg_addr      in   STREAM_W   mask table index
//  cfg_wdata     in   NUM_REGEX  mask value
//  cfg_flush     in   1          invalidate all flow table entries
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; all table entries invalid; mask table all-ones; rr_ptr 0.
//  FSM: IDLE -> LOOKUP -> LOAD -> GAP -> STREAM -> EOP -> IDLE.
//   IDLE: pkt_rdy = pkt_vld & ~pkt_sop (stray non-sop bytes consumed and dropped).
//     On pkt_vld & pkt_sop: capture pkt_key, no byte consumed -> LOOKUP.
//   LOOKUP: parallel compare against all valid entries. Hit: lowest matching index, new=0.
//     Miss: lowest invalid index; if table full, victim = rr_ptr, then rr_ptr += 1 (wraps 63->0).
//     On miss, write key and set valid. -> LOAD.
//   LOAD: load_state=1 for one cycle; stream_id, new_stream_id and enable = mask[id] registered here.
//     Values hold until the EOP cycle completes. -> GAP.
//   GAP: one idle cycle so matcher state_in_vld lands before the first char. -> STREAM.
//   STREAM: pkt_rdy=1. Each accepted byte appears on char_in with char_in_vld=1 on the next cycle.
//     pkt_vld gaps give char_in_vld=0 cycles. pkt_sop inside STREAM is ignored (treated as data).
//     Accepted byte with pkt_eop -> EOP.
//   EOP: pkt_rdy=0, char_in_vld=0, eop=1 for exactly one cycle after the last char_in_vld. -> IDLE.
//  Latencies:
//   - sop-seen to load_state: 2 cycles.
//   - load_state to earliest char_in_vld: 3 cycles.
//   - Single-byte packet (sop&eop): one char then eop.
//  Config:
//   - cfg_we writes mask[cfg_addr] at any time; the current packet keeps its latched enable.
//   - cfg_flush clears all valid bits next edge and does not disturb the packet in flight.
//   - If cfg_flush and a LOOKUP miss-write occur in the same cycle, flush wins; the entry is invalid afterward.
//  Async reset mid-packet: outputs drop to 0 immediately; partial packet is abandoned; no eop is issued.
// CONFIGURATION
//  DPI_SEQ_STATS_EN defined: extra outputs, each wrapping at 2**32, reset to 0:
//   - stat_pkts[31:0]: +1 per eop.
//   - stat_bytes[31:0]: +1 per char_in_vld.
//   - stat_drops[31:0]: +1 per stray IDLE byte.
//   - stat_evict[31:0]: +1 per full-table miss.
//  DPI_SEQ_STATS_EN undefined: those ports and counters are absent; all other behaviour is identical.
// TESTING
//  1. Reset, then key 0x1234 with bytes "ABC" -> load_state with id=0, new=1;
//     then 0x41, 0x42, 0x43 on 3 consecutive cycles; eop on the next cycle.
//  2. Repeat key 0x1234 -> id=0, new=0; then key 0x5678 -> id=1, new=1;
//     cfg mask[1]=0x0005 beforehand -> enable=0x0005.
//  3. 64 distinct keys, then 65th and 66th new keys -> id=0, new=1 and id=1, new=1;
//     the original key of entry 0 then misses.
//  4. 4-byte packet with pkt_vld low 2 cycles after byte 2 -> char_in_vld pattern 1,1,0,0,1,1;
//     eop one cycle after the last char.
//  5. Non-sop bytes 0xAA,0xBB in IDLE then a 1-byte sop&eop packet -> stray bytes dropped;
//     one char; eop; stat_drops=2 with DPI_SEQ_STATS_EN.
//  6. rst_n low during STREAM -> all outputs 0 without waiting for a clock edge;
//     next key 0x1234 -> id=0, new=1; cfg_flush then 0x1234 -> new=1.

Source files
------------

// File: rtl/dpi_stream_sequencer_if.sv
// rtl/dpi_stream_sequencer_if.sv - framed packet byte stream into the sequencer
interface dpi_stream_sequencer_if #(
  parameter int KEY_W = 16
) ();
  logic [7:0]       pkt_data;
  logic             pkt_vld;
  logic             pkt_sop;
  logic             pkt_eop;
  logic [KEY_W-1:0] pkt_key;
  logic             pkt_rdy;

  modport master (
    output pkt_data, pkt_vld, pkt_sop, pkt_eop, pkt_key,
    input  pkt_rdy
  );

  modport slave (
    input  pkt_data, pkt_vld, pkt_sop, pkt_eop, pkt_key,
    output pkt_rdy
  );
endinterface

// File: rtl/dpi_stream_sequencer.sv
// rtl/dpi_stream_sequencer.sv - maps flow keys to stream ids and drives the matcher load/char/eop protocol
// Optional counters (stat_*_o) are built when DPI_SEQ_STATS_EN is defined.
module dpi_stream_sequencer #(
  parameter int NUM_REGEX = 16,
  parameter int KEY_W     = 16,
  parameter int STREAM_W  = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dpi_stream_sequencer_if.slave pkt,
  output logic [7:0]           char_in_o,
  output logic                 char_in_vld_o,
  output logic                 eop_o,
  output logic                 load_state_o,
  output logic [STREAM_W-1:0]  stream_id_o,
  output logic                 new_stream_id_o,
  output logic [NUM_REGEX-1:0] enable_o,
  input  logic                 cfg_we_i,
  input  logic [STREAM_W-1:0]  cfg_addr_i,
  input  logic [NUM_REGEX-1:0] cfg_wdata_i,
  input  logic                 cfg_flush_i
`ifdef DPI_SEQ_STATS_EN
  ,
  output logic [31:0]          stat_pkts_o,
  output logic [31:0]          stat_bytes_o,
  output logic [31:0]          stat_drops_o,
  output logic [31:0]          stat_evict_o
`endif
);

  localparam int NUM_STREAMS = 2**STREAM_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_LOAD, S_GAP, S_STREAM, S_EOP
  } state_t;

  state_t                state_q, state_d;
  logic                  pkt_rdy_c;

  logic [KEY_W-1:0]      key_q;
  logic [KEY_W-1:0]      tbl_key_q [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] tbl_vld_q;
  logic [NUM_REGEX-1:0]  mask_q [NUM_STREAMS];
  logic [STREAM_W-1:0]   rr_ptr_q;

  logic [7:0]            char_q;
  logic                  char_vld_q;
  logic                  eop_q;
  logic                  load_q;
  logic [STREAM_W-1:0]   id_q;
  logic                  new_q;
  logic [NUM_REGEX-1:0]  en_q;

  logic                  hit;
  logic                  free;
  logic [STREAM_W-1:0]   hit_idx;
  logic [STREAM_W-1:0]   free_idx;
  logic [STREAM_W-1:0]   lk_id;
  logic                  in_lookup;
  logic                  lk_miss;
  logic                  lk_evict;
  logic                  stray_byte;
  logic                  byte_acc;

  // Descending scan so the lowest matching / lowest free index wins.
  always_comb begin
    hit      = 1'b0;
    free     = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
      if (tbl_vld_q[i] && (tbl_key_q[i] == key_q)) begin
        hit     = 1'b1;
        hit_idx = STREAM_W'(i);
      end
      if (!tbl_vld_q[i]) begin
        free     = 1'b1;
        free_idx = STREAM_W'(i);
      end
    end
  end

  assign lk_id      = hit ? hit_idx : (free ? free_idx : rr_ptr_q);
  assign in_lookup  = (state_q == S_LOOKUP);
  assign lk_miss    = in_lookup && !hit;
  assign lk_evict   = lk_miss && !free;
  assign stray_byte = (state_q == S_IDLE) && pkt.pkt_vld && !pkt.pkt_sop;
  assign byte_acc   = (state_q == S_STREAM) && pkt.pkt_vld;

  always_comb begin
    state_d   = state_q;
    pkt_rdy_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        pkt_rdy_c = pkt.pkt_vld && !pkt.pkt_sop;
        if (pkt.pkt_vld && pkt.pkt_sop) state_d = S_LOOKUP;
      end
      S_LOOKUP: state_d = S_LOAD;
      S_LOAD:   state_d = S_GAP;
      S_GAP:    state_d = S_STREAM;
      S_STREAM: begin
        pkt_rdy_c = 1'b1;
        if (pkt.pkt_vld && pkt.pkt_eop) state_d = S_EOP;
      end
      S_EOP:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign pkt.pkt_rdy = pkt_rdy_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      key_q      <= '0;
      char_q     <= '0;
      char_vld_q <= 1'b0;
      eop_q      <= 1'b0;
      load_q     <= 1'b0;
      id_q       <= '0;
      new_q      <= 1'b0;
      en_q       <= '0;
    end else begin
      state_q    <= state_d;
      char_vld_q <= byte_acc;
      eop_q      <= (state_q == S_EOP);
      load_q     <= in_lookup;
      if (state_q == S_IDLE && pkt.pkt_vld && pkt.pkt_sop) key_q <= pkt.pkt_key;
      if (byte_acc) char_q <= pkt.pkt_data;
      // Stream context is latched once per packet and released after the eop pulse.
      if (in_lookup) begin
        id_q  <= lk_id;
        new_q <= !hit;
        en_q  <= mask_q[lk_id];
      end else if (eop_q) begin
        id_q  <= '0;
        new_q <= 1'b0;
        en_q  <= '0;
      end
    end
  end

  // Flush takes priority over a same-cycle miss allocation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_vld_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      if (cfg_flush_i) tbl_vld_q <= '0;
      else if (lk_miss) tbl_vld_q[lk_id] <= 1'b1;
      if (lk_evict) rr_ptr_q <= rr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (lk_miss) tbl_key_q[lk_id] <= key_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STREAMS; i++) mask_q[i] <= '1;
    end else if (cfg_we_i) begin
      mask_q[cfg_addr_i] <= cfg_wdata_i;
    end
  end

  assign char_in_o       = char_q;
  assign char_in_vld_o   = char_vld_q;
  assign eop_o           = eop_q;
  assign load_state_o    = load_q;
  assign stream_id_o     = id_q;
  assign new_stream_id_o = new_q;
  assign enable_o        = en_q;

`ifdef DPI_SEQ_STATS_EN
  logic [31:0] stat_pkts_q, stat_bytes_q, stat_drops_q, stat_evict_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pkts_q  <= '0;
      stat_bytes_q <= '0;
      stat_drops_q <= '0;
      stat_evict_q <= '0;
    end else begin
      if (eop_q)      stat_pkts_q  <= stat_pkts_q + 32'd1;
      if (char_vld_q) stat_bytes_q <= stat_bytes_q + 32'd1;
      if (stray_byte) stat_drops_q <= stat_drops_q + 32'd1;
      if (lk_evict)   stat_evict_q <= stat_evict_q + 32'd1;
    end
  end

  assign stat_pkts_o  = stat_pkts_q;
  assign stat_bytes_o = stat_bytes_q;
  assign stat_drops_o = stat_drops_q;
  assign stat_evict_o = stat_evict_q;
`else
  logic unused_stray;
  assign unused_stray = stray_byte;
`endif

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// tb/tb_dpi_stream_sequencer.sv - directed bench with a flow-table/queue reference model
module tb_dpi_stream_sequencer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  char_in;
  logic        char_in_vld, eop, load_state, new_stream_id;
  logic [5:0]  stream_id;
  logic [15:0] enable;
  logic        cfg_we, cfg_flush;
  logic [5:0]  cfg_addr;
  logic [15:0] cfg_wdata;
`ifdef DPI_SEQ_STATS_EN
  logic [31:0] stat_pkts, stat_bytes, stat_drops, stat_evict;
`endif

  dpi_stream_sequencer_if #(.KEY_W(16)) pkt_if ();

  dpi_stream_sequencer dut (
    .clk(clk), .rst_n(rst_n), .pkt(pkt_if),
    .char_in_o(char_in), .char_in_vld_o(char_in_vld), .eop_o(eop),
    .load_state_o(load_state), .stream_id_o(stream_id),
    .new_stream_id_o(new_stream_id), .enable_o(enable),
    .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
    .cfg_flush_i(cfg_flush)
`ifdef DPI_SEQ_STATS_EN
    , .stat_pkts_o(stat_pkts), .stat_bytes_o(stat_bytes),
    .stat_drops_o(stat_drops), .stat_evict_o(stat_evict)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: flow table as plain arrays plus expected-output queues.
  logic [15:0] m_key   [64];
  bit          m_valid [64];
  logic [15:0] m_mask  [64];
  int          m_rr;

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0;
      m_key[i]   = '0;
      m_mask[i]  = 16'hFFFF;
    end
    m_rr = 0;
  endfunction

  function automatic void model_flush();
    for (int i = 0; i < 64; i++) m_valid[i] = 0;
  endfunction

  function automatic void model_lookup(input logic [15:0] key, output logic [5:0] id, output logic nw);
    int slot = -1;
    for (int i = 0; i < 64; i++)
      if (m_valid[i] && m_key[i] == key) begin slot = i; break; end
    if (slot >= 0) begin
      id = 6'(slot);
      nw = 1'b0;
      return;
    end
    for (int i = 0; i < 64; i++)
      if (!m_valid[i]) begin slot = i; break; end
    if (slot < 0) begin
      slot = m_rr;
      m_rr = (m_rr + 1) % 64;
    end
    m_key[slot]   = key;
    m_valid[slot] = 1;
    id = 6'(slot);
    nw = 1'b1;
  endfunction

  typedef struct packed {
    logic [5:0]  id;
    logic        nw;
    logic [15:0] en;
    logic [7:0]  n;
  } exp_t;

  exp_t       exp_q [$];
  logic [7:0] exp_b [$];
  logic [7:0] pbuf  [8];
  int pkts_sent = 0;
  int pkts_done = 0;

  // Per-packet observations captured by the compare process.
  exp_t        cur;
  bit          in_pkt = 0;
  int          nchar, load_cyc, first_char_cyc, last_char_cyc, eop_cyc, sop_cyc;
  logic [5:0]  last_id;
  logic        last_new;
  logic [15:0] last_en;
  logic [15:0] pat;
  int          plen;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_b.delete();
      in_pkt = 0;
    end else begin
      if (load_state) begin
        check("load_expected", 32'(!in_pkt && exp_q.size() > 0), 32'd1);
        if (!in_pkt && exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          in_pkt = 1; nchar = 0; pat = '0; plen = 0;
          load_cyc = cyc;
          last_id = stream_id; last_new = new_stream_id; last_en = enable;
          check("new_stream_id", 32'(new_stream_id), 32'(cur.nw));
        end
      end
      if (in_pkt) begin
        check("stream_id", 32'(stream_id), 32'(cur.id));
        check("enable", 32'(enable), 32'(cur.en));
      end
      if (char_in_vld) begin
        if (!in_pkt || exp_b.size() == 0) begin
          check("char_expected", 32'd0, 32'd1);
        end else begin
          check("char_data", 32'(char_in), 32'(exp_b.pop_front()));
          nchar++;
          if (nchar == 1) first_char_cyc = cyc;
          last_char_cyc = cyc;
        end
      end
      if (in_pkt && nchar > 0 && !eop) begin
        pat = {pat[14:0], char_in_vld};
        plen++;
      end
      if (eop) begin
        check("eop_in_packet", 32'(in_pkt), 32'd1);
        if (in_pkt) begin
          check("eop_char_count", 32'(nchar), 32'(cur.n));
          check("eop_after_last_char", 32'(cyc - last_char_cyc), 32'd1);
          check("eop_no_char", 32'(char_in_vld), 32'd0);
          in_pkt = 0;
          eop_cyc = cyc;
          pkts_done++;
        end
      end
    end
  end

  task automatic idle_inputs();
    pkt_if.pkt_vld  = 1'b0;
    pkt_if.pkt_sop  = 1'b0;
    pkt_if.pkt_eop  = 1'b0;
    pkt_if.pkt_data = '0;
  endtask

  task automatic drive_byte(input int i, input int n, input logic sop);
    pkt_if.pkt_vld  = 1'b1;
    pkt_if.pkt_sop  = sop;
    pkt_if.pkt_data = pbuf[i];
    pkt_if.pkt_eop  = (i == n - 1);
  endtask

  task automatic send_pkt(input logic [15:0] key, input int n, input int gap_after,
                          input int gap_len, input bit flush_lk, input int abort_after);
    logic [5:0] id;
    logic       nw;
    exp_t       e;
    logic       rdy;
    int         i = 0;
    int         edges = 0;
    model_lookup(key, id, nw);
    e.id = id; e.nw = nw; e.en = m_mask[id]; e.n = 8'(n);
    if (flush_lk) model_flush();
    exp_q.push_back(e);
    for (int k = 0; k < n; k++) exp_b.push_back(pbuf[k]);
    pkts_sent++;
    sop_cyc = cyc;
    pkt_if.pkt_key = key;
    drive_byte(0, n, 1'b1);
    while (i < n) begin
      @(negedge clk);
      rdy = pkt_if.pkt_rdy;
      @(posedge clk);
      #1;
      edges++;
      if (flush_lk) cfg_flush = (edges == 1);
      if (rdy) begin
        i++;
        if (i == abort_after) return;
        if (i == n) idle_inputs();
        else begin
          if (i - 1 == gap_after) begin
            pkt_if.pkt_vld = 1'b0;
            repeat (gap_len) @(posedge clk);
            #1;
          end
          drive_byte(i, n, 1'b0);
        end
      end
      if (edges > 200) begin
        check("send_timeout", 32'd0, 32'd1);
        idle_inputs();
        break;
      end
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (pkts_done < pkts_sent && t < 300) begin
      @(posedge clk);
      t++;
    end
    if (pkts_done < pkts_sent) check("wait_idle_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [5:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    m_mask[a] = d;
  endtask

  task automatic cfg_flush_pulse();
    cfg_flush = 1'b1;
    @(posedge clk); #1;
    cfg_flush = 1'b0;
    model_flush();
  endtask

  task automatic stray(input logic [7:0] d);
    pkt_if.pkt_vld = 1'b1; pkt_if.pkt_sop = 1'b0; pkt_if.pkt_data = d;
    @(negedge clk);
    check("stray_rdy", 32'(pkt_if.pkt_rdy), 32'd1);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  function automatic logic [31:0] all_outs();
    return {char_in_vld, eop, load_state, new_stream_id, pkt_if.pkt_rdy, stream_id, enable} | 32'(char_in);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    rst_n = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_flush = 1'b0;
    pkt_if.pkt_key = '0;
    idle_inputs();
    model_reset();
    #1 rst_n = 1'b0;
    #1 check("reset_outputs", all_outs(), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Test 1: "ABC" on a fresh table.
    pbuf[0] = 8'h41; pbuf[1] = 8'h42; pbuf[2] = 8'h43;
    send_pkt(16'h1234, 3, -1, 0, 1'b0, -1);
    wait_idle();
    check("t1_id", 32'(last_id), 32'd0);
    check("t1_new", 32'(last_new), 32'd1);
    check("t1_enable", 32'(last_en), 32'hFFFF);
    check("t1_sop_to_load", 32'(load_cyc - sop_cyc), 32'd2);
    check("t1_load_to_char", 32'(first_char_cyc - load_cyc), 32'd3);
    check("t1_char_pattern", 32'(pat), 32'b111);
    check("t1_eop_lat", 32'(eop_cyc - first_char_cyc), 32'd3);

    // Test 2: hit, then a new key with a configured mask.
    cfg_write(6'd1, 16'h0005);
    pbuf[0] = 8'h10; pbuf[1] = 8'h11;
    send_pkt(16'h1234, 2, -1, 0, 1'b0, -1);
    wait_idle();
    check("t2_hit_id", 32'(last_id), 32'd0);
    check("t2_hit_new", 32'(last_new), 32'd0);
    send_pkt(16'h5678, 1, -1, 0, 1'b0, -1);
    wait_idle();
    check("t2_miss_id", 32'(last_id), 32'd1);
    check("t2_miss_new", 32'(last_new), 32'd1);
    check("t2_enable", 32'(last_en), 32'h0005);

    // Test 4: input gap of two cycles after the second byte.
    pbuf[0] = 8'hD0; pbuf[1] = 8'hD1; pbuf[2] = 8'hD2; pbuf[3] = 8'hD3;
    send_pkt(16'h9ABC, 4, 1, 2, 1'b0, -1);
    wait_idle();
    check("t4_id", 32'(last_id), 32'd2);
    check("t4_pattern_len", 32'(plen), 32'd6);
    check("t4_pattern", 32'(pat), 32'b110011);
    check("t4_eop_lat", 32'(eop_cyc - last_char_cyc), 32'd1);

    // Test 5: stray bytes in IDLE, then a single-byte packet.
    stray(8'hAA);
    stray(8'hBB);
    pbuf[0] = 8'h5A;
    send_pkt(16'h1234, 1, -1, 0, 1'b0, -1);
    wait_idle();
    check("t5_id", 32'(last_id), 32'd0);
    check("t5_single_char", 32'(eop_cyc - first_char_cyc), 32'd1);
`ifdef DPI_SEQ_STATS_EN
    check("t5_stat_drops", stat_drops, 32'd2);
    check("t5_stat_pkts", stat_pkts, 32'd5);
    check("t5_stat_bytes", stat_bytes, 32'd11);
`endif

    // Test 3: fill the table, then two evictions and a re-miss of entry 0's key.
    cfg_flush_pulse();
    for (int k = 0; k < 64; k++) begin
      pbuf[0] = 8'(k);
      send_pkt(16'h1000 + 16'(k), 1, -1, 0, 1'b0, -1);
    end
    wait_idle();
    check("t3_fill_last_id", 32'(last_id), 32'd63);
    pbuf[0] = 8'hE0;
    send_pkt(16'h2000, 1, -1, 0, 1'b0, -1);
    wait_idle();
    check("t3_evict0_id", 32'(last_id), 32'd0);
    check("t3_evict0_new", 32'(last_new), 32'd1);
    send_pkt(16'h2001, 1, -1, 0, 1'b0, -1);
    wait_idle();
    check("t3_evict1_id", 32'(last_id), 32'd1);
    check("t3_evict1_new", 32'(last_new), 32'd1);
    send_pkt(16'h1000, 1, -1, 0, 1'b0, -1);
    wait_idle();
    check("t3_old_key_new", 32'(last_new), 32'd1);
    check("t3_old_key_id", 32'(last_id), 32'd2);
`ifdef DPI_SEQ_STATS_EN
    check("t3_stat_evict", stat_evict, 32'd3);
`endif

    // Test 6: asynchronous reset in the middle of a packet.
    pbuf[0] = 8'h01; pbuf[1] = 8'h02; pbuf[2] = 8'h03; pbuf[3] = 8'h04;
    send_pkt(16'h4444, 4, -1, 0, 1'b0, 2);
    check("t6_pre_reset_vld", 32'(char_in_vld), 32'd1);
    idle_inputs();
    #2 rst_n = 1'b0;
    #1 check("t6_reset_outputs", all_outs(), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    pkts_sent = pkts_done;
    @(posedge clk); #1;
    pbuf[0] = 8'h77;
    send_pkt(16'h1234, 1, -1, 0, 1'b0, -1);
    wait_idle();
    check("t6_after_reset_id", 32'(last_id), 32'd0);
    check("t6_after_reset_new", 32'(last_new), 32'd1);
    cfg_flush_pulse();
    send_pkt(16'h1234, 1, -1, 0, 1'b0, -1);
    wait_idle();
    check("t6_after_flush_new", 32'(last_new), 32'd1);

    // Flush coinciding with a miss allocation leaves the entry invalid.
    send_pkt(16'h7777, 1, -1, 0, 1'b1, -1);
    wait_idle();
    check("t6_flush_lk_id", 32'(last_id), 32'd1);
    send_pkt(16'h7777, 1, -1, 0, 1'b0, -1);
    wait_idle();
    check("t6_flush_wins_new", 32'(last_new), 32'd1);
    check("t6_flush_wins_id", 32'(last_id), 32'd0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
